// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Two-requester controller in front of the single-port, word-wide firmware
// memory. Port 0 is the CPU native memory port, port 1 the firmware
// loader/debug port. Requests are arbitrated round-robin and sequenced into
// the memory's one-cycle-latency read and word write. Byte-strobed partial
// writes are turned into read-modify-write because the memory only has a
// word write enable.
//
// Handshake (both ports): the requester raises mX_valid with addr/wdata/wstrb
// stable and holds them until mX_ready. mX_ready is a one-cycle completion
// pulse. For reads, mX_rdata is already valid in the ready cycle and is held
// until the next read completes on that same port. Requests are sampled only
// when the controller is idle. Once granted, a transaction always runs to
// completion even if valid drops, unless reset aborts it.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   m0_* / m1_*             requester ports (valid, addr, wdata, wstrb in;
//                           ready, rdata out). wstrb == 0 means read.
//   mem_wen/addr/wdata      memory write enable, word address, write data
//   mem_rdata               memory read data, valid the cycle after mem_addr
//   grant                   one-hot owner of the current transaction, 0 idle
//   dbg_state               current FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module rom_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,

    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,

    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic [1:0]        grant,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_DATA = 3'd2,
        S_WR   = 3'd3,
        S_ACK  = 3'd4
    } state_t;

    state_t      state;
    logic        last_port;   // port granted most recently (1 = port 1)
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    // -------------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the port that was not
    // granted last wins. Only consulted in IDLE.
    // -------------------------------------------------------------------------
    logic        win1;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_wstrb;

    always_comb begin
        if (m0_valid && m1_valid) begin
            win1 = ~last_port;
        end else begin
            win1 = m1_valid;
        end
        win_addr  = win1 ? m1_addr  : m0_addr;
        win_wdata = win1 ? m1_wdata : m0_wdata;
        win_wstrb = win1 ? m1_wstrb : m0_wstrb;
    end

    // Byte offset and bits above the memory range are ignored on purpose:
    // out-of-range addresses alias onto the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{win_addr[31:ADDR_W+2], win_addr[1:0]};

    // -------------------------------------------------------------------------
    // Read-modify-write merge: strobed bytes from the request, the rest from
    // the word read back in the DATA cycle.
    // -------------------------------------------------------------------------
    logic [31:0] merged;

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer. All outputs are registered here.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            last_port <= 1'b1;     // port 0 wins the first tie after reset
            grant     <= 2'b00;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant     <= win1 ? 2'b10 : 2'b01;
                        last_port <= win1;
                        mem_addr  <= win_addr[ADDR_W+1:2];
                        wdata_q   <= win_wdata;
                        wstrb_q   <= win_wstrb;
                        if (win_wstrb == 4'hF) begin
                            // Full-word write needs no read; raise the write
                            // enable so it is high throughout WR.
                            mem_wdata <= win_wdata;
                            mem_wen   <= 1'b1;
                            state     <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end

                S_RD: begin
                    // Memory samples mem_addr at the end of this cycle.
                    state <= S_DATA;
                end

                S_DATA: begin
                    if (wstrb_q == 4'h0) begin
                        if (grant[1]) begin
                            m1_rdata <= mem_rdata;
                        end else begin
                            m0_rdata <= mem_rdata;
                        end
                        m0_ready <= grant[0];
                        m1_ready <= grant[1];
                        state    <= S_ACK;
                    end else begin
                        mem_wdata <= merged;
                        mem_wen   <= 1'b1;
                        state     <= S_WR;
                    end
                end

                S_WR: begin
                    mem_wen  <= 1'b0;
                    m0_ready <= grant[0];
                    m1_ready <= grant[1];
                    state    <= S_ACK;
                end

                S_ACK: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    grant    <= 2'b00;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
